ball_fsm: RTL
=============

// Module: ball_fsm
//
// PURPOSE
//  Consumer of game_logic bounce events; owns ball state for Pong.
//  Holds ball x/y position and direction, advances one STEP per move tick,
//  flips direction on paddle/wall bounce, detects misses and emits point pulses.
//  Serves from screen centre after a post-point hold-off.
//  Position outputs feed back to game_logic and to the video renderer.
//
// PARAMETERS
//  SCREEN_X     100  playfield width in pixels; legal x = 0..SCREEN_X-1
//  SCREEN_Y     100  playfield height in pixels; legal y = 0..SCREEN_Y-1
//  POS_W        7    position bus width; must satisfy 2**POS_W >= max(SCREEN_X,SCREEN_Y)
//  STEP         1    pixels moved per tick on each axis
//  SERVE_DELAY  60   ticks held in HOLD after a point
//
// PORTS
//  clock       in   1      system clock, rising edge
//  reset_n     in   1      asynchronous, active-low reset
//  tick        in   1      one-cycle move strobe (frame rate)
//  serve       in   1      one-cycle start request; honoured only in IDLE
//  bounce      in   2      00 none, 01 paddle (flip x), 10 wall (flip y), 11 reserved (ignored)
//  ball_pos_x  out  POS_W  ball x position
//  ball_pos_y  out  POS_W  ball y position
//  dir_x       out  1      1 = +x (toward paddle 2), 0 = -x
//  dir_y       out  1      1 = +y, 0 = -y
//  in_play     out  1      high in PLAY only
//  point_p1    out  1      one-cycle pulse: ball missed paddle 2 (x reached SCREEN_X-1)
//  point_p2    out  1      one-cycle pulse: ball missed paddle 1 (x reached 0)
//
// BEHAVIOUR
//  Reset values: pos = (SCREEN_X/2, SCREEN_Y/2); dir_x=1; dir_y=1; state IDLE;
//   in_play, point_p1, point_p2, pending flags and hold counter all 0.
//  States: IDLE -serve-> PLAY -miss-> SCORED -(1 cycle)-> HOLD -(SERVE_DELAY ticks)-> IDLE.
//  IDLE: ball parked at centre; tick ignored. serve: dir_x toward the loser of the last point
//   (+x after reset), dir_y unchanged.
//  PLAY, bounce latching:
//   - bounce=01 sets pend_x; bounce=10 sets pend_y. Flags are sticky until the next tick.
//   - Repeated bounces before a tick collapse into a single flip per axis.
//  PLAY, on tick (same-cycle bounce is included):
//   - Flip dir_x if pend_x; flip dir_y if pend_y; clear both flags.
//   - Step each axis by STEP using the new direction.
//   - Result registered; outputs change on the clock after the tick (latency 1).
//  Arithmetic: compute in POS_W+1 bits; clamp x to [0, SCREEN_X-1] and y to [0, SCREEN_Y-1].
//   No wrap-around is permitted.
//  Wall safety: if a y step would clamp, flip dir_y even with no wall bounce.
//  Miss: if post-step x == 0, or x == SCREEN_X-1, with no paddle flip this tick:
//   -> SCORED; pulse point_p2 (x=0) or point_p1 (x=max) in SCORED; in_play drops.
//  A paddle flip on the edge tick suppresses the miss; the ball leaves the edge next tick.
//  HOLD: position frozen at the miss point; counts ticks; at SERVE_DELAY re-centre and
//   go to IDLE. bounce and serve are ignored in SCORED and HOLD.
//  reset_n low at any time: immediate return to reset values; a point pulse in flight is dropped.
//
// STRUCTURE
//  Shared package pong_pkg:
//   - BOUNCE_NONE/PADDLE/WALL codes
//   - ball state encoding
//   - SCREEN_X/SCREEN_Y defaults, also used by game_logic
//  Sub-module serve_timer: tick-enabled down-counter, load/done, width $clog2(SERVE_DELAY+1).
//
// TESTING
//  1 Reset, serve, 3 ticks, no bounce -> pos (53,53); dir_x=1; dir_y=1; in_play=1.
//  2 At (60,50) dir_x=1: bounce=01 one cycle, then tick -> dir_x=0; pos (59,51).
//     Two 01 pulses before one tick -> single flip only.
//  3 y=99, dir_y=1, tick with no bounce -> y stays 99; dir_y=0; next tick y=98.
//     bounce=10 on the same cycle as the tick -> flip applied that tick.
//  4 x=1, dir_x=0, tick, no bounce -> x=0; one-cycle point_p2; in_play=0.
//     After 60 ticks -> IDLE at (50,50); next serve gives dir_x=0.
//  5 x=1, dir_x=0: bounce=01 and tick in the same cycle -> x=2; dir_x=1; no point pulse.
//  6 reset_n low mid-PLAY and in HOLD (counter=30) -> (50,50), IDLE, counter 0, outputs 0.
//     serve in HOLD -> ignored.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong definitions: bounce codes, ball state encoding and playfield defaults.
package pong_pkg;

  localparam logic [1:0] BOUNCE_NONE   = 2'b00;
  localparam logic [1:0] BOUNCE_PADDLE = 2'b01;
  localparam logic [1:0] BOUNCE_WALL   = 2'b10;

  localparam int SCREEN_X_DEF = 100;
  localparam int SCREEN_Y_DEF = 100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_SCORED = 2'd2,
    ST_HOLD   = 2'd3
  } ball_state_e;

endpackage

// File: rtl/ball_fsm_serve_timer.sv
// Tick-enabled down-counter timing the post-point hold-off; done fires on the final tick.
module serve_timer #(
  parameter int SERVE_DELAY = 60,
  localparam int CW = $clog2(SERVE_DELAY + 1)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  input  logic tick,
  output logic done
);

  logic [CW-1:0] cnt;

  assign done = tick && (cnt == CW'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                  cnt <= '0;
    else if (load)                 cnt <= CW'(SERVE_DELAY);
    else if (tick && cnt != '0)    cnt <= cnt - CW'(1);
  end

endmodule

// File: rtl/ball_fsm.sv
// Pong ball owner: position/direction, pending bounce flags, miss detection and serve hold-off.
module ball_fsm
  import pong_pkg::*;
#(
  parameter int SCREEN_X    = SCREEN_X_DEF,
  parameter int SCREEN_Y    = SCREEN_Y_DEF,
  parameter int POS_W       = 7,
  parameter int STEP        = 1,
  parameter int SERVE_DELAY = 60
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             serve,
  input  logic [1:0]       bounce,
  output logic [POS_W-1:0] ball_pos_x,
  output logic [POS_W-1:0] ball_pos_y,
  output logic             dir_x,
  output logic             dir_y,
  output logic             in_play,
  output logic             point_p1,
  output logic             point_p2
);

  localparam logic [POS_W:0]   STEP_E = (POS_W+1)'(STEP);
  localparam logic [POS_W:0]   X_MAX  = (POS_W+1)'(SCREEN_X - 1);
  localparam logic [POS_W:0]   Y_MAX  = (POS_W+1)'(SCREEN_Y - 1);
  localparam logic [POS_W-1:0] X_CTR  = POS_W'(SCREEN_X / 2);
  localparam logic [POS_W-1:0] Y_CTR  = POS_W'(SCREEN_Y / 2);

  ball_state_e      state, state_n;
  logic [POS_W-1:0] pos_x, pos_y, pos_x_n, pos_y_n;
  logic             dx_n, dy_n, pend_x, pend_y, pend_x_n, pend_y_n;
  logic             last_hi, last_hi_n;   // last miss was at x max: serve goes +x
  logic             flip_x, flip_y, new_dx, dy_f, new_dy, y_clamp, miss, hold_done;
  logic [POS_W:0]   step_x, step_y;

  // One-tick step; extra bit keeps the edge arithmetic from wrapping.
  always_comb begin
    flip_x  = pend_x | (bounce == BOUNCE_PADDLE);
    flip_y  = pend_y | (bounce == BOUNCE_WALL);
    new_dx  = dir_x ^ flip_x;
    dy_f    = dir_y ^ flip_y;
    step_x  = {1'b0, pos_x};
    step_y  = {1'b0, pos_y};
    y_clamp = 1'b0;
    if (new_dx) step_x = (step_x + STEP_E > X_MAX) ? X_MAX : step_x + STEP_E;
    else        step_x = (step_x < STEP_E) ? '0 : step_x - STEP_E;
    if (dy_f) begin
      y_clamp = (step_y + STEP_E > Y_MAX);
      step_y  = y_clamp ? Y_MAX : step_y + STEP_E;
    end else begin
      y_clamp = (step_y < STEP_E);
      step_y  = y_clamp ? '0 : step_y - STEP_E;
    end
    new_dy = dy_f ^ y_clamp;
    miss   = !flip_x && (step_x == '0 || step_x == X_MAX);
  end

  always_comb begin
    state_n   = state;
    pos_x_n   = pos_x;
    pos_y_n   = pos_y;
    dx_n      = dir_x;
    dy_n      = dir_y;
    pend_x_n  = pend_x;
    pend_y_n  = pend_y;
    last_hi_n = last_hi;
    case (state)
      ST_IDLE: if (serve) begin
        state_n  = ST_PLAY;
        dx_n     = last_hi;
        pend_x_n = 1'b0;
        pend_y_n = 1'b0;
      end
      ST_PLAY: if (tick) begin
        pos_x_n  = step_x[POS_W-1:0];
        pos_y_n  = step_y[POS_W-1:0];
        dx_n     = new_dx;
        dy_n     = new_dy;
        pend_x_n = 1'b0;
        pend_y_n = 1'b0;
        if (miss) begin
          state_n   = ST_SCORED;
          last_hi_n = (step_x == X_MAX);
        end
      end else begin
        pend_x_n = flip_x;
        pend_y_n = flip_y;
      end
      ST_SCORED: state_n = ST_HOLD;
      ST_HOLD: if (hold_done) begin
        state_n = ST_IDLE;
        pos_x_n = X_CTR;
        pos_y_n = Y_CTR;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      pos_x   <= X_CTR;
      pos_y   <= Y_CTR;
      dir_x   <= 1'b1;
      dir_y   <= 1'b1;
      pend_x  <= 1'b0;
      pend_y  <= 1'b0;
      last_hi <= 1'b1;
    end else begin
      state   <= state_n;
      pos_x   <= pos_x_n;
      pos_y   <= pos_y_n;
      dir_x   <= dx_n;
      dir_y   <= dy_n;
      pend_x  <= pend_x_n;
      pend_y  <= pend_y_n;
      last_hi <= last_hi_n;
    end
  end

  serve_timer #(.SERVE_DELAY(SERVE_DELAY)) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (state == ST_SCORED),
    .tick    (tick && state == ST_HOLD),
    .done    (hold_done)
  );

  assign ball_pos_x = pos_x;
  assign ball_pos_y = pos_y;
  assign in_play    = (state == ST_PLAY);
  assign point_p1   = (state == ST_SCORED) &&  last_hi;
  assign point_p2   = (state == ST_SCORED) && !last_hi;

endmodule
